d_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the scalar load/store unit and main memory.
- On the memory side it is the data-port initiator: it drives d_cache_mem_vis_signal/addr, written_data and data_type, and consumes mem_data/mem_status.
- Memory bandwidth is 4 bytes per beat. Memory returns and accepts bytes in memory order: bits [31:24] hold the byte at addr.
- The block converts between memory byte order and little-endian CPU values, and fills whole lines on read misses.

---
 rtl/d_cache.sv | 218 +++++++++++++++++++++
 tb/tb_d_cache.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// It fills 16-byte lines in 4-byte beats and swaps between memory byte order and little-endian CPU values.
`timescale 1ns/1ps
`ifndef ONE_BYTE
`define ONE_BYTE 3'd1
`define TWO_BYTE 3'd2
`define FOUR_BYTE 3'd3
`define EIGHT_BYTE 3'd4
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'd0
`define MEM_READ 2'd1
`define MEM_WRITE 2'd2
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'd0
`define MEM_DATA_FINISHED 2'd1
`define MEM_INST_FINISHED 2'd2
`endif

// state     | meaning
// IDLE      | waiting for cpu_request
// LOOKUP    | tag/valid compare, store-hit update
// FILL_REQ  | MEM_READ of one beat on the bus
// FILL_WAIT | waiting for that beat's data
// WR_REQ    | MEM_WRITE on the bus
// WR_WAIT   | waiting for the write to finish
// RESPOND   | cpu_done pulse
module d_cache #(
  parameter int ADDR_WIDTH        = 17,
  parameter int DATA_LEN          = 32,
  parameter int BYTE_SIZE         = 8,
  parameter int LINE_OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH       = 6,
  parameter int ENTRY_INDEX_SIZE  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_request,
  input  logic                        cpu_write,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [2:0]                  cpu_data_type,
  input  logic [DATA_LEN-1:0]         cpu_written_data,
  output logic                        cpu_busy,
  output logic                        cpu_done,
  output logic [DATA_LEN-1:0]         cpu_read_data,
  output logic [1:0]                  d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr,
  output logic [ENTRY_INDEX_SIZE:0]   length,
  output logic [DATA_LEN-1:0]         written_data,
  output logic [2:0]                  data_type,
  input  logic [DATA_LEN-1:0]         mem_data,
  input  logic [1:0]                  mem_status
);
  localparam int TAG_W      = ADDR_WIDTH - INDEX_WIDTH - LINE_OFFSET_WIDTH;
  localparam int LINE_BYTES = 1 << LINE_OFFSET_WIDTH;
  localparam int NUM_LINES  = 1 << INDEX_WIDTH;
  localparam int WORD_BYTES = DATA_LEN / BYTE_SIZE;
  localparam int WB_W       = $clog2(WORD_BYTES);
  localparam int BEAT_W     = LINE_OFFSET_WIDTH - WB_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESPOND} state_t;

  state_t                      state;
  logic                        req_write;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [2:0]                  req_type;
  logic [DATA_LEN-1:0]         req_wdata;
  logic [BEAT_W-1:0]           beat;
  logic [NUM_LINES-1:0]        valid;
  logic [TAG_W-1:0]            tag_mem [NUM_LINES];
  logic [BYTE_SIZE-1:0]        line_data [NUM_LINES][LINE_BYTES];

  logic [TAG_W-1:0]             req_tag;
  logic [INDEX_WIDTH-1:0]       req_index;
  logic [LINE_OFFSET_WIDTH-1:0] req_off;
  logic                         hit, mem_done, last_beat, fill_we, store_we;
  logic [DATA_LEN-1:0]          result;

  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_index = req_addr[LINE_OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_off   = req_addr[LINE_OFFSET_WIDTH-1:0];
  assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign mem_done  = (mem_status == `MEM_DATA_FINISHED);
  assign last_beat = (beat == {BEAT_W{1'b1}});
  assign fill_we   = (state == FILL_WAIT) && mem_done;
  assign store_we  = (state == LOOKUP) && req_write && hit;
  assign length    = '0;

  function automatic int size_bytes(input logic [2:0] dt);
    case (dt)
      `ONE_BYTE: return 1;
      `TWO_BYTE: return 2;
      default:   return WORD_BYTES;
    endcase
  endfunction

  // Byte k of a bus word in memory order: k=0 is the MSB byte.
  function automatic logic [BYTE_SIZE-1:0] word_byte(input logic [DATA_LEN-1:0] w, input int k);
    logic [DATA_LEN-1:0] t;
    t = w << (k * BYTE_SIZE);
    return t[DATA_LEN-1 -: BYTE_SIZE];
  endfunction

  function automatic logic [DATA_LEN-1:0] to_mem_order(input logic [DATA_LEN-1:0] v);
    logic [DATA_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      r[DATA_LEN-1-i*BYTE_SIZE -: BYTE_SIZE] = v[i*BYTE_SIZE +: BYTE_SIZE];
    return r;
  endfunction

  // Load result; on the final fill beat the incoming word bypasses the array.
  always_comb begin
    logic [LINE_OFFSET_WIDTH-1:0] pos;
    logic [BYTE_SIZE-1:0]         b;
    int                           n;
    result = '0;
    pos    = '0;
    b      = '0;
    n      = size_bytes(req_type);
    for (int i = 0; i < WORD_BYTES; i++) begin
      pos = req_off + LINE_OFFSET_WIDTH'(i);
      b   = line_data[req_index][pos];
      if (state == FILL_WAIT && pos[LINE_OFFSET_WIDTH-1:WB_W] == beat)
        b = word_byte(mem_data, int'(pos[WB_W-1:0]));
      if (i < n) result[i*BYTE_SIZE +: BYTE_SIZE] = b;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      for (int k = 0; k < WORD_BYTES; k++)
        line_data[req_index][{beat, WB_W'(k)}] <= word_byte(mem_data, k);
      if (last_beat) tag_mem[req_index] <= req_tag;
    end
    if (store_we) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (i < size_bytes(req_type))
          line_data[req_index][req_off + LINE_OFFSET_WIDTH'(i)] <= req_wdata[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      valid                  <= '0;
      req_write              <= 1'b0;
      req_addr               <= '0;
      req_type               <= '0;
      req_wdata              <= '0;
      beat                   <= '0;
      cpu_busy               <= 1'b0;
      cpu_done               <= 1'b0;
      cpu_read_data          <= '0;
      d_cache_mem_vis_signal <= `MEM_NOP;
      d_cache_mem_vis_addr   <= '0;
      written_data           <= '0;
      data_type              <= '0;
    end else begin
      cpu_done               <= 1'b0;
      d_cache_mem_vis_signal <= `MEM_NOP;
      case (state)
        IDLE: if (cpu_request) begin
          req_write <= cpu_write;
          req_addr  <= cpu_addr;
          req_type  <= cpu_data_type;
          req_wdata <= cpu_written_data;
          cpu_busy  <= 1'b1;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (req_write) begin
            d_cache_mem_vis_signal <= `MEM_WRITE;
            d_cache_mem_vis_addr   <= req_addr;
            data_type              <= req_type;
            written_data           <= to_mem_order(req_wdata);
            state                  <= WR_REQ;
          end else if (hit) begin
            cpu_read_data <= result;
            cpu_done      <= 1'b1;
            cpu_busy      <= 1'b0;
            state         <= RESPOND;
          end else begin
            valid[req_index]       <= 1'b0;
            beat                   <= '0;
            d_cache_mem_vis_signal <= `MEM_READ;
            d_cache_mem_vis_addr   <= {req_tag, req_index, {LINE_OFFSET_WIDTH{1'b0}}};
            state                  <= FILL_REQ;
          end
        end
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: if (mem_done) begin
          if (last_beat) begin
            valid[req_index] <= 1'b1;
            cpu_read_data    <= result;
            cpu_done         <= 1'b1;
            cpu_busy         <= 1'b0;
            state            <= RESPOND;
          end else begin
            beat                   <= beat + 1'b1;
            d_cache_mem_vis_signal <= `MEM_READ;
            d_cache_mem_vis_addr   <= {req_tag, req_index, beat + 1'b1, {WB_W{1'b0}}};
            state                  <= FILL_REQ;
          end
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: if (mem_done) begin
          cpu_done <= 1'b1;
          cpu_busy <= 1'b0;
          state    <= RESPOND;
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_cache.sv
// Scoreboard bench for d_cache: a byte-array memory with a random-latency responder,
// a line-residency model that predicts bus commands and load results, and decoupled monitors.
`timescale 1ns/1ps
`ifndef ONE_BYTE
`define ONE_BYTE 3'd1
`define TWO_BYTE 3'd2
`define FOUR_BYTE 3'd3
`define EIGHT_BYTE 3'd4
`endif
`ifndef MEM_NOP
`define MEM_NOP 2'd0
`define MEM_READ 2'd1
`define MEM_WRITE 2'd2
`endif
`ifndef MEM_RESTING
`define MEM_RESTING 2'd0
`define MEM_DATA_FINISHED 2'd1
`define MEM_INST_FINISHED 2'd2
`endif

module tb_d_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_request = 1'b0;
  logic        cpu_write = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [2:0]  cpu_data_type = '0;
  logic [31:0] cpu_written_data = '0;
  logic        cpu_busy, cpu_done;
  logic [31:0] cpu_read_data;
  logic [1:0]  vis;
  logic [16:0] vis_addr;
  logic [3:0]  length;
  logic [31:0] written_data;
  logic [2:0]  data_type;
  logic [31:0] mem_data = '0;
  logic [1:0]  mem_status = `MEM_RESTING;

  d_cache dut (
    .clk(clk), .rst(rst), .cpu_request(cpu_request), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_data_type(cpu_data_type), .cpu_written_data(cpu_written_data),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_read_data(cpu_read_data),
    .d_cache_mem_vis_signal(vis), .d_cache_mem_vis_addr(vis_addr), .length(length),
    .written_data(written_data), .data_type(data_type),
    .mem_data(mem_data), .mem_status(mem_status)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_load; logic [31:0] data; int lat;} resp_t;
  typedef struct {logic [1:0] cmd; logic [16:0] addr; logic [2:0] dt; logic [31:0] wd;} cmd_t;
  resp_t resp_q[$];
  cmd_t  cmd_q[$];

  logic [7:0] mem     [0:131071];
  logic [7:0] ref_mem [0:131071];
  bit         m_valid [64];
  logic [6:0] m_tag   [64];

  int checks = 0, passes = 0;
  int cyc = 0, acc = 0, rd_seen = 0, lat_cfg = 0;
  bit          pend = 0, pend_rd = 0;
  int          pend_cnt = 0;
  logic [16:0] pend_addr = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] dt);
    if (dt == `ONE_BYTE) return 1;
    if (dt == `TWO_BYTE) return 2;
    return 4;
  endfunction

  // Main memory: accepts a command, answers after 0..lat_cfg extra cycles.
  always @(negedge clk) begin
    mem_status = `MEM_RESTING;
    mem_data   = $urandom;
    if (rst) pend = 0;
    else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_status = `MEM_DATA_FINISHED;
          if (pend_rd) for (int k = 0; k < 4; k++) mem_data[31-8*k -: 8] = mem[17'(pend_addr + k)];
          pend = 0;
        end else begin
          pend_cnt--;
          if ($urandom_range(0, 1) == 1) mem_status = `MEM_INST_FINISHED;
        end
      end
      if (vis == `MEM_READ || vis == `MEM_WRITE) begin
        pend      = 1;
        pend_rd   = (vis == `MEM_READ);
        pend_addr = vis_addr;
        pend_cnt  = $urandom_range(0, lat_cfg);
        if (vis == `MEM_WRITE)
          for (int i = 0; i < nbytes(data_type); i++) mem[17'(vis_addr + i)] = written_data[31-8*i -: 8];
      end
    end
  end

  // Command monitor
  always @(negedge clk) begin
    if (!rst && vis != `MEM_NOP) begin
      if (vis == `MEM_READ) rd_seen++;
      if (cmd_q.size() == 0) chk("unexpected_cmd", {30'd0, vis}, {30'd0, `MEM_NOP});
      else begin
        cmd_t e;
        e = cmd_q.pop_front();
        chk("cmd", {30'd0, vis}, {30'd0, e.cmd});
        chk("cmd_addr", {15'd0, vis_addr}, {15'd0, e.addr});
        if (e.cmd == `MEM_WRITE) begin
          chk("wr_type", {29'd0, data_type}, {29'd0, e.dt});
          chk("wr_data", written_data, e.wd);
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst && cpu_done) begin
      if (resp_q.size() == 0) chk("unexpected_done", {31'd0, cpu_done}, 32'd0);
      else begin
        resp_t r;
        r = resp_q.pop_front();
        if (r.is_load) chk("load_data", cpu_read_data, r.data);
        chk("busy_at_done", {31'd0, cpu_busy}, 32'd0);
        if (r.lat >= 0) chk("latency", cyc - acc + 1, r.lat);
      end
    end
  end

  task automatic model_issue(input bit wr, input logic [16:0] a, input logic [2:0] dt,
                             input logic [31:0] wd, input int lat);
    int n; int idx; logic [6:0] tg; resp_t r; cmd_t c; logic [31:0] v;
    n = nbytes(dt); idx = int'(a[9:4]); tg = a[16:10];
    r.is_load = !wr; r.lat = lat; r.data = '0;
    if (wr) begin
      v = '0;
      for (int i = 0; i < 4; i++) v[31-8*i -: 8] = wd[8*i +: 8];
      c.cmd = `MEM_WRITE; c.addr = a; c.dt = dt; c.wd = v;
      cmd_q.push_back(c);
      for (int i = 0; i < n; i++) ref_mem[17'(a + i)] = wd[8*i +: 8];
    end else begin
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
        for (int b = 0; b < 4; b++) begin
          c.cmd = `MEM_READ; c.addr = {a[16:4], 4'd0} + 17'(4 * b); c.dt = '0; c.wd = '0;
          cmd_q.push_back(c);
        end
        m_valid[idx] = 1; m_tag[idx] = tg;
      end
      for (int i = 0; i < n; i++) r.data[8*i +: 8] = ref_mem[17'(a + i)];
    end
    resp_q.push_back(r);
  endtask

  task automatic drive_req(input bit wr, input logic [16:0] a, input logic [2:0] dt,
                           input logic [31:0] wd, input bit poke);
    @(negedge clk);
    cpu_request = 1; cpu_write = wr; cpu_addr = a; cpu_data_type = dt; cpu_written_data = wd;
    @(posedge clk); #1;
    acc = cyc;
    cpu_request = 0;
    if (poke) begin
      // A request while busy must be ignored.
      cpu_request = 1; cpu_write = ~wr; cpu_addr = a ^ 17'h0c40; cpu_data_type = `FOUR_BYTE & 3'b111;
      cpu_written_data = $urandom;
      @(posedge clk); #1;
      cpu_request = 0;
    end
  endtask

  task automatic do_access(input bit wr, input logic [16:0] a, input logic [2:0] dt,
                           input logic [31:0] wd, input int lat, input bit poke);
    bit seen;
    model_issue(wr, a, dt, wd, lat);
    drive_req(wr, a, dt, wd, poke);
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (cpu_done) seen = 1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL done_timeout: got no cpu_done expected done within 300 cycles addr %h", a);
    end
  endtask

  initial begin
    int base;
    bit got;
    for (int a = 0; a < 131072; a++) mem[a] = 8'($urandom);
    for (int a = 'h100; a < 'h110; a++) mem[a] = 8'(a - 'h100);
    for (int a = 0; a < 131072; a++) ref_mem[a] = mem[a];
    for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_tag[i] = '0; end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_vis", {30'd0, vis}, {30'd0, `MEM_NOP});
    chk("rst_rdata", cpu_read_data, 32'd0);
    @(negedge clk); rst = 0;

    do_access(0, 17'h104, `FOUR_BYTE, 0, 10, 0);
    do_access(0, 17'h10A, `TWO_BYTE, 0, 2, 1);
    do_access(1, 17'h105, `ONE_BYTE, 32'h000000AA, 4, 0);
    do_access(0, 17'h104, `FOUR_BYTE, 0, 2, 0);
    do_access(1, 17'h200, `FOUR_BYTE, 32'h11223344, 4, 1);
    do_access(0, 17'h200, `FOUR_BYTE, 0, 10, 0);
    do_access(0, 17'h204, `EIGHT_BYTE, 0, 2, 0);

    // Reset in the FILL_WAIT of beat 2 of a fresh fill.
    do_access(0, 17'h500, `FOUR_BYTE, 0, 10, 0);
    model_issue(0, 17'h108, `FOUR_BYTE, 0, -1);
    base = rd_seen;
    drive_req(0, 17'h108, `FOUR_BYTE, 0, 0);
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk); #1;
      if (rd_seen >= base + 3) got = 1;
    end
    if (!got) begin
      checks++;
      $display("FAIL rst_setup: got %0d reads expected 3", rd_seen - base);
    end
    @(negedge clk); #1;
    rst = 1; #1;
    chk("midrst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("midrst_vis", {30'd0, vis}, {30'd0, `MEM_NOP});
    chk("midrst_addr", {15'd0, vis_addr}, 32'd0);
    chk("midrst_rdata", cpu_read_data, 32'd0);
    repeat (2) @(negedge clk);
    cmd_q.delete(); resp_q.delete();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    #1 rst = 0;

    do_access(0, 17'h100, `FOUR_BYTE, 0, 10, 0);
    do_access(0, 17'h500, `FOUR_BYTE, 0, 10, 0);
    do_access(0, 17'h100, `FOUR_BYTE, 0, 10, 0);
    do_access(0, 17'h10C, `ONE_BYTE, 0, 2, 0);

    lat_cfg = 3;
    for (int k = 0; k < 150; k++) begin
      bit wr; logic [2:0] dt; logic [16:0] a; int n; int off;
      wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: dt = `ONE_BYTE;
        1: dt = `TWO_BYTE;
        2: dt = `FOUR_BYTE;
        default: dt = `EIGHT_BYTE;
      endcase
      n = nbytes(dt);
      off = $urandom_range(0, 15);
      off = off - (off % n);
      a = 17'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | off);
      do_access(wr, a, dt, $urandom, -1, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
